bus_demux_decoder: RTL and testbench
====================================

// Module: bus_demux_decoder
// PURPOSE
//  Slave-side front end of the system bus; sits between the cpu pins and the bus slaves.
//  - Demultiplexes the cpu's multiplexed address/data bus: latches Data as Address while ALE is high.
//  - Decodes the latched address into active-low slave selects (RAM, LEDs, switches, timer, serial).
//  - Merges slave wait requests into nWait and slave interrupt requests into nIRQ.
// PARAMETERS
//  RAM_TOP     16'h7FFF  highest RAM word address; RAM spans 0x0000..RAM_TOP
//  IO_BASE     16'hA000  base of I/O page
//  SERIAL_WS   1         wait states inserted on every new serial access (0..7)
// PORTS
//  Clock        in   1   system clock, all state on rising edge
//  nReset       in   1   synchronous reset, active low
//  Data         in   16  multiplexed address/data bus (observed only, never driven)
//  ALE          in   1   address latch enable, high = Data carries address
//  nME          in   1   memory/IO access enable, active low
//  nOE          in   1   output enable, active low (read strobe)
//  RnW          in   1   1 = read, 0 = write
//  Test         in   1   scan/test mode
//  wait_timer   in   1   timer requests wait (active high)
//  irq_timer    in   1   timer interrupt request (active high, level)
//  irq_serial   in   1   serial interrupt request (active high, level)
//  irq_mask     in   2   per-source enable {serial,timer}, 1 = enabled
//  Address      out  16  latched address
//  nSelRAM, nSelLED, nSelSwitch, nSelTimer, nSelSerial  out 1 each  selects, active low
//  nWait        out  1   low = cpu must stall
//  nIRQ         out  1   low = interrupt pending to cpu
//  bus_err      out  1   one-cycle pulse on access to unmapped address
// BEHAVIOUR
//  Reset (nReset=0 at rising Clock): Address=0, all nSel*=1, nWait=1, nIRQ=1, bus_err=0, wait counter=0.
//  Address latch: on rising Clock with ALE=1, Address<=Data. Otherwise Address holds. Latency 1 cycle.
//  Decode, combinational from Address, qualified by nME=0 and Test=0:
//   - 0x0000..RAM_TOP -> nSelRAM
//   - IO_BASE+0 -> nSelLED
//   - IO_BASE+1 -> nSelSwitch
//   - IO_BASE+2..+3 -> nSelTimer
//   - IO_BASE+4..+7 -> nSelSerial
//   - all other addresses -> unmapped, no select
//   - At most one select low at any time. nME=1 or Test=1 forces all selects high.
//  Access start: nME high->low, detected with a registered copy of nME.
//   - Start with an unmapped Address -> bus_err=1 for exactly that cycle.
//  Wait generation:
//   - Serial access start loads counter with SERIAL_WS. nWait=0 while counter!=0; counter decrements each cycle.
//   - nWait is also 0 whenever nSelTimer=0 and wait_timer=1.
//   - nME returning high clears the counter immediately, giving nWait=1 next cycle.
//   - SERIAL_WS=0 -> no serial wait states. Test=1 forces nWait=1.
//  Interrupts: nIRQ <= ~((irq_timer&irq_mask[0]) | (irq_serial&irq_mask[1])), registered, 1-cycle latency, level-sensitive.
//  ALE=1 while nME=0: address updates and selects follow the new address; no glitch-protection is required.
//  RnW and nOE do not affect decode; they are passed to slaves unchanged outside this block.
//  Simultaneous reset and ALE: reset wins.
// STRUCTURE
//  Package bus_pkg: address map constants (RAM_TOP, IO_BASE, slave offsets) and a slave-index enum
//   {SEL_NONE, SEL_RAM, SEL_LED, SEL_SWITCH, SEL_TIMER, SEL_SERIAL}.
//  One sub-module sel_decode: pure combinational Address -> slave enum; the top converts the enum to active-low selects.
//  Top holds the address register, nME edge detect, wait counter, and IRQ register.
// TESTING
//  Reset: hold nReset=0 2 cycles with ALE=1, Data=0x1234 -> Address=0, all nSel*=1, nWait=1, nIRQ=1.
//  Latch/decode: ALE=1, Data=0x0400 1 cycle, then nME=0 -> Address=0x0400, nSelRAM=0 only.
//   Repeat for 0xA000/0xA001/0xA003/0xA005 -> LED/Switch/Timer/Serial select respectively.
//  Unmapped: Address=0x9000, nME falls -> no select, bus_err=1 for exactly 1 cycle.
//  Wait: SERIAL_WS=1, access 0xA004 -> nWait=0 for 1 cycle, then 1.
//   Timer access with wait_timer=1 -> nWait=0 until wait_timer drops.
//  IRQ: irq_timer=1, mask=2'b01 -> nIRQ=0 next cycle. Mask=2'b10 -> nIRQ=1.
//   irq_serial=1 -> nIRQ=0.
//  Test mode: Test=1 during RAM access -> all selects high, nWait=1.

Source files
------------

// File: rtl/bus_demux_decoder_pkg.sv
// Address map and slave identifiers shared by the bus front end.
//   RAM_TOP_DEFAULT / IO_BASE_DEFAULT : default address map
//   *_OFS                             : slave offsets inside the I/O page
//   slave_t                           : which slave an address belongs to
package bus_demux_decoder_pkg;

    typedef logic [15:0] addr_t;

    localparam addr_t RAM_TOP_DEFAULT = 16'h7FFF;
    localparam addr_t IO_BASE_DEFAULT = 16'hA000;

    // I/O page layout: LED @+0, switches @+1, timer @+2..+3, serial @+4..+7
    localparam addr_t LED_OFS    = 16'd0;
    localparam addr_t SWITCH_OFS = 16'd1;
    localparam addr_t TIMER_OFS  = 16'd2;
    localparam addr_t SERIAL_OFS = 16'd4;
    localparam addr_t IO_SPAN    = 16'd8;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_LED,
        SEL_SWITCH,
        SEL_TIMER,
        SEL_SERIAL
    } slave_t;

endpackage

// File: rtl/bus_demux_decoder_if.sv
// CPU-side multiplexed bus.
//   Data/ALE/nME/nOE/RnW : driven by the cpu (master)
//   Address              : latched address, driven by the front end (slave)
//   nWait/nIRQ           : stall and interrupt back to the cpu
interface bus_demux_decoder_if;

    logic [15:0] Data;
    logic        ALE;
    logic        nME;
    logic        nOE;
    logic        RnW;
    logic [15:0] Address;
    logic        nWait;
    logic        nIRQ;

    modport master (
        output Data, ALE, nME, nOE, RnW,
        input  Address, nWait, nIRQ
    );

    modport slave (
        input  Data, ALE, nME, nOE, RnW,
        output Address, nWait, nIRQ
    );

endinterface

// File: rtl/bus_demux_decoder_sel_decode.sv
// Combinational address decoder: Address -> slave identifier.
//   Address in  16  latched bus address
//   slave   out     slave owning that address (SEL_NONE if unmapped)
// RAM takes priority should the I/O page ever be placed inside RAM.
module bus_demux_decoder_sel_decode
    import bus_demux_decoder_pkg::*;
#(
    parameter addr_t RAM_TOP = RAM_TOP_DEFAULT,
    parameter addr_t IO_BASE = IO_BASE_DEFAULT
) (
    input  addr_t  Address,
    output slave_t slave
);

    addr_t offset;

    always_comb begin
        slave  = SEL_NONE;
        offset = Address - IO_BASE;
        if (Address <= RAM_TOP) begin
            slave = SEL_RAM;
        end else if (Address >= IO_BASE && offset < IO_SPAN) begin
            if (offset < SWITCH_OFS)      slave = SEL_LED;
            else if (offset < TIMER_OFS)  slave = SEL_SWITCH;
            else if (offset < SERIAL_OFS) slave = SEL_TIMER;
            else                          slave = SEL_SERIAL;
        end
    end

endmodule

// File: rtl/bus_demux_decoder.sv
// Slave-side front end of the system bus.
//   Clock, nReset      : clock and synchronous active-low reset
//   bus (slave)        : multiplexed cpu bus; Address/nWait/nIRQ returned
//   Test               : test mode, forces selects inactive and nWait high
//   wait_timer         : timer stall request
//   irq_timer/serial   : level interrupt requests
//   irq_mask           : {serial,timer} interrupt enables
//   nSel*              : active-low slave selects
//   bus_err            : pulse on an access start to an unmapped address
module bus_demux_decoder
    import bus_demux_decoder_pkg::*;
#(
    parameter addr_t       RAM_TOP   = RAM_TOP_DEFAULT,
    parameter addr_t       IO_BASE   = IO_BASE_DEFAULT,
    parameter int unsigned SERIAL_WS = 1
) (
    input  logic                        Clock,
    input  logic                        nReset,
    bus_demux_decoder_if.slave          bus,
    input  logic                        Test,
    input  logic                        wait_timer,
    input  logic                        irq_timer,
    input  logic                        irq_serial,
    input  logic [1:0]                  irq_mask,
    output logic                        nSelRAM,
    output logic                        nSelLED,
    output logic                        nSelSwitch,
    output logic                        nSelTimer,
    output logic                        nSelSerial,
    output logic                        bus_err
);

    localparam logic [2:0] WS_LOAD = 3'(SERIAL_WS);

    addr_t      addr_q;
    logic       nme_q;
    logic [2:0] ws_cnt;
    logic       nirq_q;
    slave_t     slave;
    logic       access_start;
    logic       sel_active;
    logic       unused_strobes;

    bus_demux_decoder_sel_decode #(
        .RAM_TOP (RAM_TOP),
        .IO_BASE (IO_BASE)
    ) u_sel_decode (
        .Address (addr_q),
        .slave   (slave)
    );

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            addr_q <= '0;
            nme_q  <= 1'b1;
            ws_cnt <= '0;
            nirq_q <= 1'b1;
        end else begin
            if (bus.ALE) addr_q <= bus.Data;
            nme_q  <= bus.nME;
            nirq_q <= ~((irq_timer & irq_mask[0]) | (irq_serial & irq_mask[1]));
            if (bus.nME)
                ws_cnt <= '0;
            else if (access_start && slave == SEL_SERIAL)
                ws_cnt <= WS_LOAD;
            else if (ws_cnt != '0)
                ws_cnt <= ws_cnt - 3'd1;
        end
    end

    // nME falling edge marks the first cycle of an access
    assign access_start = nme_q & ~bus.nME;
    assign sel_active   = ~bus.nME & ~Test;

    always_comb begin
        nSelRAM    = 1'b1;
        nSelLED    = 1'b1;
        nSelSwitch = 1'b1;
        nSelTimer  = 1'b1;
        nSelSerial = 1'b1;
        if (sel_active) begin
            case (slave)
                SEL_RAM:    nSelRAM    = 1'b0;
                SEL_LED:    nSelLED    = 1'b0;
                SEL_SWITCH: nSelSwitch = 1'b0;
                SEL_TIMER:  nSelTimer  = 1'b0;
                SEL_SERIAL: nSelSerial = 1'b0;
                default:    ;
            endcase
        end
    end

    assign bus_err     = access_start & (slave == SEL_NONE);
    assign bus.Address = addr_q;
    assign bus.nWait   = Test | ~((ws_cnt != '0) | (~nSelTimer & wait_timer));
    assign bus.nIRQ    = nirq_q;

    // Strobes are routed to the slaves elsewhere; they do not affect decode
    assign unused_strobes = bus.nOE ^ bus.RnW;

endmodule

// File: tb/tb_bus_demux_decoder.sv
module tb_bus_demux_decoder;

    localparam int TB_WS = 1;

    logic       Clock = 1'b0;
    logic       nReset = 1'b0;
    logic       Test = 1'b0;
    logic       wait_timer = 1'b0;
    logic       irq_timer = 1'b0;
    logic       irq_serial = 1'b0;
    logic [1:0] irq_mask = 2'b00;
    logic       nSelRAM, nSelLED, nSelSwitch, nSelTimer, nSelSerial, bus_err;

    bus_demux_decoder_if bus();

    bus_demux_decoder #(
        .RAM_TOP   (16'h7FFF),
        .IO_BASE   (16'hA000),
        .SERIAL_WS (TB_WS)
    ) dut (
        .Clock      (Clock),
        .nReset     (nReset),
        .bus        (bus),
        .Test       (Test),
        .wait_timer (wait_timer),
        .irq_timer  (irq_timer),
        .irq_serial (irq_serial),
        .irq_mask   (irq_mask),
        .nSelRAM    (nSelRAM),
        .nSelLED    (nSelLED),
        .nSelSwitch (nSelSwitch),
        .nSelTimer  (nSelTimer),
        .nSelSerial (nSelSerial),
        .bus_err    (bus_err)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Selects packed as {Serial, Timer, Switch, LED, RAM}
    localparam logic [4:0] NS_NONE = 5'b11111;
    localparam logic [4:0] NS_RAM  = 5'b11110;
    localparam logic [4:0] NS_LED  = 5'b11101;
    localparam logic [4:0] NS_SW   = 5'b11011;
    localparam logic [4:0] NS_TMR  = 5'b10111;
    localparam logic [4:0] NS_SER  = 5'b01111;

    function automatic logic [4:0] nsel_vec();
        return {nSelSerial, nSelTimer, nSelSwitch, nSelLED, nSelRAM};
    endfunction

    // Address map from the memory map description
    function automatic logic [4:0] ref_nsel(input int a);
        int o;
        if (a <= 'h7FFF) return NS_RAM;
        if (a >= 'hA000 && a < 'hA008) begin
            o = a - 'hA000;
            case (o)
                0:       return NS_LED;
                1:       return NS_SW;
                2, 3:    return NS_TMR;
                default: return NS_SER;
            endcase
        end
        return NS_NONE;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Reference state: latched address, previous nME, stall cycles still owed, irq level
    logic [15:0] m_addr;
    bit          m_nme_prev;
    int          m_owed;
    bit          m_nirq;

    task automatic model_reset();
        m_addr = '0; m_nme_prev = 1'b1; m_owed = 0; m_nirq = 1'b1;
    endtask

    task automatic model_edge();
        if (!nReset) begin
            model_reset();
        end else begin
            if (bus.nME) m_owed = 0;
            else if (m_nme_prev && ref_nsel(int'(m_addr)) == NS_SER) m_owed = TB_WS;
            else if (m_owed > 0) m_owed--;
            if (bus.ALE) m_addr = bus.Data;
            m_nme_prev = bus.nME;
            m_nirq = !((irq_timer && irq_mask[0]) || (irq_serial && irq_mask[1]));
        end
    endtask

    task automatic check_model();
        logic [4:0] e_nsel;
        bit e_err, e_wait;
        e_nsel = (!bus.nME && !Test) ? ref_nsel(int'(m_addr)) : NS_NONE;
        e_err  = m_nme_prev && !bus.nME && ref_nsel(int'(m_addr)) == NS_NONE;
        e_wait = Test ? 1'b1 : !(m_owed > 0 || (e_nsel == NS_TMR && wait_timer));
        chk("rnd_addr", 32'(bus.Address), 32'(m_addr));
        chk("rnd_nsel", 32'(nsel_vec()), 32'(e_nsel));
        chk("rnd_buserr", 32'(bus_err), 32'(e_err));
        chk("rnd_nwait", 32'(bus.nWait), 32'(e_wait));
        chk("rnd_nirq", 32'(bus.nIRQ), 32'(m_nirq));
    endtask

    typedef struct {
        logic [15:0] addr;
        logic        test;
        logic        wt;
        logic [4:0]  nsel;
        logic        nwait;
        logic        err;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [15:0] pick_addr();
        logic [15:0] pool[8];
        pool = '{16'h0000, 16'h7FFF, 16'h8000, 16'h9000, 16'h9FFF, 16'hA008, 16'hFFFF, 16'h0400};
        case ($urandom_range(0, 2))
            0:       return 16'hA000 + 16'($urandom_range(0, 7));
            1:       return pool[$urandom_range(0, 7)];
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        bus.Data = '0; bus.ALE = 1'b0; bus.nME = 1'b1; bus.nOE = 1'b1; bus.RnW = 1'b1;

        // Reset wins over ALE
        nReset = 1'b0; bus.ALE = 1'b1; bus.Data = 16'h1234;
        tick(); tick(); settle();
        chk("rst_addr", 32'(bus.Address), 32'h0);
        chk("rst_nsel", 32'(nsel_vec()), 32'(NS_NONE));
        chk("rst_nwait", 32'(bus.nWait), 32'h1);
        chk("rst_nirq", 32'(bus.nIRQ), 32'h1);
        chk("rst_buserr", 32'(bus_err), 32'h0);
        nReset = 1'b1; bus.ALE = 1'b0;
        tick();

        vecs[0]  = '{16'h0400, 1'b0, 1'b0, NS_RAM,  1'b1, 1'b0};
        vecs[1]  = '{16'hA000, 1'b0, 1'b0, NS_LED,  1'b1, 1'b0};
        vecs[2]  = '{16'hA001, 1'b0, 1'b0, NS_SW,   1'b1, 1'b0};
        vecs[3]  = '{16'hA003, 1'b0, 1'b0, NS_TMR,  1'b1, 1'b0};
        vecs[4]  = '{16'hA005, 1'b0, 1'b0, NS_SER,  1'b1, 1'b0};
        vecs[5]  = '{16'h9000, 1'b0, 1'b0, NS_NONE, 1'b1, 1'b1};
        vecs[6]  = '{16'h7FFF, 1'b0, 1'b0, NS_RAM,  1'b1, 1'b0};
        vecs[7]  = '{16'h8000, 1'b0, 1'b0, NS_NONE, 1'b1, 1'b1};
        vecs[8]  = '{16'hA007, 1'b0, 1'b0, NS_SER,  1'b1, 1'b0};
        vecs[9]  = '{16'hA008, 1'b0, 1'b0, NS_NONE, 1'b1, 1'b1};
        vecs[10] = '{16'h0400, 1'b1, 1'b0, NS_NONE, 1'b1, 1'b0};
        vecs[11] = '{16'hA002, 1'b0, 1'b1, NS_TMR,  1'b0, 1'b0};

        foreach (vecs[i]) begin
            bus.nME = 1'b1; bus.ALE = 1'b1; bus.Data = vecs[i].addr;
            Test = vecs[i].test; wait_timer = vecs[i].wt;
            tick();
            bus.ALE = 1'b0; bus.nME = 1'b0; bus.Data = 16'hDEAD;
            settle();
            chk("vec_addr", 32'(bus.Address), 32'(vecs[i].addr));
            chk("vec_nsel", 32'(nsel_vec()), 32'(vecs[i].nsel));
            chk("vec_nwait", 32'(bus.nWait), 32'(vecs[i].nwait));
            chk("vec_buserr", 32'(bus_err), 32'(vecs[i].err));
            tick();
            bus.nME = 1'b1; Test = 1'b0; wait_timer = 1'b0;
            tick();
        end

        // Unmapped access: bus_err only in the start cycle
        bus.ALE = 1'b1; bus.Data = 16'h9000; tick();
        bus.ALE = 1'b0; bus.nME = 1'b0; settle();
        chk("unm_err_first", 32'(bus_err), 32'h1);
        chk("unm_nsel", 32'(nsel_vec()), 32'(NS_NONE));
        tick();
        chk("unm_err_second", 32'(bus_err), 32'h0);
        bus.nME = 1'b1; tick();

        // Serial access: one stall cycle after the start cycle
        bus.ALE = 1'b1; bus.Data = 16'hA004; tick();
        bus.ALE = 1'b0; bus.nME = 1'b0; settle();
        chk("ser_nwait_start", 32'(bus.nWait), 32'h1);
        tick();
        chk("ser_nwait_stall", 32'(bus.nWait), 32'h0);
        tick();
        chk("ser_nwait_done", 32'(bus.nWait), 32'h1);
        bus.nME = 1'b1; tick();

        // Timer stall follows wait_timer
        bus.ALE = 1'b1; bus.Data = 16'hA002; wait_timer = 1'b1; tick();
        bus.ALE = 1'b0; bus.nME = 1'b0; settle();
        for (int k = 0; k < 3; k++) begin
            chk("tmr_nwait_held", 32'(bus.nWait), 32'h0);
            tick();
        end
        wait_timer = 1'b0; settle();
        chk("tmr_nwait_release", 32'(bus.nWait), 32'h1);

        // ALE during an access: selects follow the new address
        bus.ALE = 1'b1; bus.Data = 16'hA001; tick();
        bus.ALE = 1'b0; settle();
        chk("ale_addr", 32'(bus.Address), 32'hA001);
        chk("ale_nsel", 32'(nsel_vec()), 32'(NS_SW));
        chk("ale_buserr", 32'(bus_err), 32'h0);
        bus.nME = 1'b1; tick();

        // Interrupts: registered, masked per source
        irq_timer = 1'b1; irq_mask = 2'b01; settle();
        chk("irq_latency", 32'(bus.nIRQ), 32'h1);
        tick();
        chk("irq_timer_on", 32'(bus.nIRQ), 32'h0);
        irq_mask = 2'b10; tick();
        chk("irq_timer_masked", 32'(bus.nIRQ), 32'h1);
        irq_serial = 1'b1; tick();
        chk("irq_serial_on", 32'(bus.nIRQ), 32'h0);
        irq_serial = 1'b0; irq_timer = 1'b0; tick();
        chk("irq_cleared", 32'(bus.nIRQ), 32'h1);

        // Randomised run against the reference model
        nReset = 1'b0; tick();
        model_reset();
        nReset = 1'b1;
        for (int n = 0; n < 400; n++) begin
            nReset     = ($urandom_range(0, 49) != 0);
            bus.ALE    = ($urandom_range(0, 3) == 0);
            bus.Data   = pick_addr();
            if ($urandom_range(0, 2) == 0) bus.nME = ~bus.nME;
            bus.nOE    = 1'($urandom);
            bus.RnW    = 1'($urandom);
            Test       = ($urandom_range(0, 9) == 0);
            wait_timer = 1'($urandom);
            irq_timer  = 1'($urandom);
            irq_serial = 1'($urandom);
            irq_mask   = 2'($urandom);
            settle();
            check_model();
            model_edge();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
